// File: rtl/regfile_pkg.sv
// Shared defaults and the write-back record for the register-file write arbiter.
//   RF_DATA_W / RF_ADDR_W / RF_FIFO_DEPTH : default widths and queue depth
//   wb_req_t                              : one write request (register index + data)
package regfile_pkg;
  localparam int RF_DATA_W     = 32;
  localparam int RF_ADDR_W     = 5;
  localparam int RF_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rg;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between two write-back requesters and the register file.
//   reqN_valid/reqN_reg/reqN_data -> arbiter, reqN_ready <- arbiter
//   RegWrite/WriteReg/WriteData   -> register file write port
//   pending_mask                  -> one bit per register with a write in flight
// slave modport : the arbiter; master modport : requesters / register-file side.
interface regfile_wb_arbiter_if import regfile_pkg::*; #(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);
  logic                   req0_valid, req1_valid;
  logic [ADDR_W-1:0]      req0_reg,   req1_reg;
  logic [DATA_W-1:0]      req0_data,  req1_data;
  logic                   req0_ready, req1_ready;
  logic                   RegWrite;
  logic [ADDR_W-1:0]      WriteReg;
  logic [DATA_W-1:0]      WriteData;
  logic [(1<<ADDR_W)-1:0] pending_mask;

  modport slave (
    input  req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
    output req0_ready, req1_ready, RegWrite, WriteReg, WriteData, pending_mask
  );

  modport master (
    output req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
    input  req0_ready, req1_ready, RegWrite, WriteReg, WriteData, pending_mask
  );
endinterface

// File: rtl/wb_fifo.sv
// Per-requester write queue.
//   push_i/reg_i/data_i : enqueue (ignored when full)
//   pop_i               : dequeue head (ignored when empty)
//   head_*_o            : current head entry
//   full_o/empty_o      : occupancy flags, registered state only
//   vld_o/ent_reg_o     : per-slot valid and register index, for pending decode
module wb_fifo import regfile_pkg::*; #(
  parameter int DEPTH = RF_FIFO_DEPTH,
  parameter int AW    = RF_ADDR_W,
  parameter int DW    = RF_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [AW-1:0]          reg_i,
  input  logic [DW-1:0]          data_i,
  input  logic                   pop_i,
  output logic [AW-1:0]          head_reg_o,
  output logic [DW-1:0]          head_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [DEPTH-1:0]       vld_o,
  output logic [DEPTH-1:0][AW-1:0] ent_reg_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]           wr_q, rd_q;
  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [DEPTH-1:0][AW-1:0] reg_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic                    do_push, do_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy is the per-slot valid vector; entries are always contiguous.
  assign full_o  = &vld_q;
  assign empty_o = ~|vld_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pop and push never hit the same slot: push needs a free slot, pop an occupied one.
  always_comb begin
    vld_d = vld_q;
    if (do_pop)  vld_d[rd_q] = 1'b0;
    if (do_push) vld_d[wr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (do_push) wr_q <= inc(wr_q);
      if (do_pop)  rd_q <= inc(rd_q);
    end
  end

  // Payload storage needs no reset; it is only observed through vld_q.
  always_ff @(posedge clk) begin
    if (do_push) begin
      reg_q[wr_q]  <= reg_i;
      data_q[wr_q] <= data_i;
    end
  end

  assign head_reg_o  = reg_q[rd_q];
  assign head_data_o = data_q[rd_q];
  assign vld_o       = vld_q;
  assign ent_reg_o   = reg_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file write-back arbiter.
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : two valid/ready write request ports, registered register-file
//                    write port (RegWrite/WriteReg/WriteData) and pending_mask.
// Each requester feeds its own queue; one head per cycle is granted round-robin
// into a registered output stage. Writes to register 0 are accepted and dropped.
module regfile_wb_arbiter import regfile_pkg::*; #(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int FIFO_DEPTH = RF_FIFO_DEPTH
) (
  input  logic               clock,
  input  logic               reset_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NREQ = 2;
  localparam int NREG = 1 << ADDR_W;

  logic [NREQ-1:0]                           vld, full, empty, push, gnt;
  logic [NREQ-1:0][ADDR_W-1:0]               in_reg, hd_reg;
  logic [NREQ-1:0][DATA_W-1:0]               in_data, hd_data;
  logic [NREQ-1:0][FIFO_DEPTH-1:0]           ent_vld;
  logic [NREQ-1:0][FIFO_DEPTH-1:0][ADDR_W-1:0] ent_reg;

  logic              last_q;   // 1: requester 1 was granted last, so 0 wins a tie
  logic              rw_q;
  logic [ADDR_W-1:0] wreg_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NREG-1:0]   pm;

  assign vld     = {bus.req1_valid, bus.req0_valid};
  assign in_reg  = {bus.req1_reg,   bus.req0_reg};
  assign in_data = {bus.req1_data,  bus.req0_data};

  // Ready is pure state; a full queue refuses even when it pops on the same edge.
  assign bus.req0_ready = ~full[0];
  assign bus.req1_ready = ~full[1];

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign push[g] = vld[g] & ~full[g] & (in_reg[g] != '0);

    wb_fifo #(.DEPTH(FIFO_DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_fifo (
      .clk        (clock),
      .rst_n      (reset_n),
      .push_i     (push[g]),
      .reg_i      (in_reg[g]),
      .data_i     (in_data[g]),
      .pop_i      (gnt[g]),
      .head_reg_o (hd_reg[g]),
      .head_data_o(hd_data[g]),
      .full_o     (full[g]),
      .empty_o    (empty[g]),
      .vld_o      (ent_vld[g]),
      .ent_reg_o  (ent_reg[g])
    );
  end

  assign gnt[0] = ~empty[0] & (empty[1] | last_q);
  assign gnt[1] = ~empty[1] & ~gnt[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q  <= 1'b1;
      rw_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      rw_q <= |gnt;
      if (gnt[0]) begin
        last_q  <= 1'b0;
        wreg_q  <= hd_reg[0];
        wdata_q <= hd_data[0];
      end else if (gnt[1]) begin
        last_q  <= 1'b1;
        wreg_q  <= hd_reg[1];
        wdata_q <= hd_data[1];
      end
    end
  end

  // Pending decode covers every live queue slot plus the output stage.
  always_comb begin
    pm = '0;
    for (int i = 0; i < NREQ; i++)
      for (int e = 0; e < FIFO_DEPTH; e++)
        if (ent_vld[i][e]) pm[ent_reg[i][e]] = 1'b1;
    if (rw_q) pm[wreg_q] = 1'b1;
  end

  assign bus.RegWrite     = rw_q;
  assign bus.WriteReg     = wreg_q;
  assign bus.WriteData    = wdata_q;
  assign bus.pending_mask = pm;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset state, single write latency,
// round-robin streaming, backpressure, r0 drop, mid-run reset and queue wrap.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  regfile_wb_arbiter_if bus ();
  regfile_wb_arbiter u_dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  int nchk = 0;
  int nerr = 0;
  int got_reg[$];
  int got_dat[$];
  int got_cyc[$];
  logic rdy0_tr [0:31];
  logic rdy1_tr [0:31];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0; bus.req0_reg = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_reg = '0; bus.req1_data = '0;
  endtask

  // Leaves time at a negedge with reset released; the next posedge is edge 1.
  task automatic do_reset();
    idle();
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
  endtask

  // Requester N offers regs bN, bN+1, ... (nN of them), advancing only on accept.
  // Data = 0x1000+reg for requester 0, 0x2000+reg for requester 1.
  task automatic run_stream(input int n0, input int n1, input int b0, input int b1, input int ncyc);
    int  i0, i1;
    logic a0, a1;
    i0 = 0; i1 = 0;
    got_reg.delete(); got_dat.delete(); got_cyc.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (bus.RegWrite) begin
        got_reg.push_back(int'(bus.WriteReg));
        got_dat.push_back(int'(bus.WriteData));
        got_cyc.push_back(c);
      end
      rdy0_tr[c] = bus.req0_ready;
      rdy1_tr[c] = bus.req1_ready;
      bus.req0_valid = (i0 < n0);
      bus.req0_reg   = RF_ADDR_W'(b0 + i0);
      bus.req0_data  = RF_DATA_W'(32'h1000 + b0 + i0);
      bus.req1_valid = (i1 < n1);
      bus.req1_reg   = RF_ADDR_W'(b1 + i1);
      bus.req1_data  = RF_DATA_W'(32'h2000 + b1 + i1);
      #1;
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      tick();
      if (a0) i0++;
      if (a1) i1++;
    end
    idle();
  endtask

  initial begin
    int exp_rr [8];
    int r, d;
    logic all_rdy;
    exp_rr = '{1, 5, 2, 6, 3, 7, 4, 8};
    idle();

    // Reset state while reset is held
    #3;
    chk("rst_regwrite", bus.RegWrite, 0);
    chk("rst_writereg", bus.WriteReg, 0);
    chk("rst_writedata", bus.WriteData, 0);
    chk("rst_pending", bus.pending_mask, 0);
    chk("rst_ready0", bus.req0_ready, 1);
    chk("rst_ready1", bus.req1_ready, 1);

    // Single write r3=0x11, accepted at edge 1
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd3; bus.req0_data = 32'h11;
    tick(); idle();
    chk("lat_c2_regwrite", bus.RegWrite, 0);
    chk("lat_c2_pending", bus.pending_mask, 32'h8);
    tick();
    chk("lat_c3_regwrite", bus.RegWrite, 1);
    chk("lat_c3_writereg", bus.WriteReg, 3);
    chk("lat_c3_writedata", bus.WriteData, 32'h11);
    chk("lat_c3_pending", bus.pending_mask, 32'h8);
    tick();
    chk("lat_c4_regwrite", bus.RegWrite, 0);
    chk("lat_c4_pending", bus.pending_mask, 0);

    // Write to r0 is dropped
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd0; bus.req0_data = 32'hFF;
    #1;
    chk("r0_ready_pre", bus.req0_ready, 1);
    tick(); idle();
    chk("r0_regwrite_a", bus.RegWrite, 0);
    chk("r0_pending_a", bus.pending_mask, 0);
    chk("r0_ready_post", bus.req0_ready, 1);
    tick();
    chk("r0_regwrite_b", bus.RegWrite, 0);
    chk("r0_pending_b", bus.pending_mask, 0);

    // Both requesters stream 4 writes from reset
    do_reset();
    run_stream(4, 4, 1, 5, 14);
    chk("rr_count", got_reg.size(), 8);
    for (int j = 0; j < 8; j++) begin
      r = (j < got_reg.size()) ? got_reg[j] : -1;
      d = (j < got_dat.size()) ? got_dat[j] : -1;
      chk($sformatf("rr_reg%0d", j), r, exp_rr[j]);
      chk($sformatf("rr_dat%0d", j), d, ((j % 2) ? 32'h2000 : 32'h1000) + exp_rr[j]);
    end
    chk("rr_consecutive", (got_cyc.size() == 8) ? got_cyc[7] - got_cyc[0] : -1, 7);
    // Backpressure on requester 1 within the same run
    chk("bp_rdy1_c1", rdy1_tr[1], 1);
    chk("bp_rdy1_c2", rdy1_tr[2], 0);
    chk("bp_rdy1_c3", rdy1_tr[3], 1);

    // Reset with three entries queued and one write on the output stage
    do_reset();
    run_stream(4, 4, 1, 5, 3);
    chk("mid_pending_pre", bus.pending_mask, 32'h6C);
    chk("mid_regwrite_pre", bus.RegWrite, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_regwrite", bus.RegWrite, 0);
    chk("mid_rst_writereg", bus.WriteReg, 0);
    chk("mid_rst_writedata", bus.WriteData, 0);
    chk("mid_rst_pending", bus.pending_mask, 0);
    chk("mid_rst_ready1", bus.req1_ready, 1);
    @(negedge clock); reset_n = 1'b1;
    tick();
    chk("mid_post_regwrite_a", bus.RegWrite, 0);
    chk("mid_post_pending", bus.pending_mask, 0);
    tick();
    chk("mid_post_regwrite_b", bus.RegWrite, 0);

    // Wrap-around: six back-to-back writes on requester 0
    do_reset();
    run_stream(6, 0, 10, 0, 10);
    chk("wrap_count", got_reg.size(), 6);
    for (int j = 0; j < 6; j++) begin
      r = (j < got_reg.size()) ? got_reg[j] : -1;
      d = (j < got_dat.size()) ? got_dat[j] : -1;
      chk($sformatf("wrap_reg%0d", j), r, 10 + j);
      chk($sformatf("wrap_dat%0d", j), d, 32'h1000 + 10 + j);
    end
    chk("wrap_consecutive", (got_cyc.size() == 6) ? got_cyc[5] - got_cyc[0] : -1, 5);
    all_rdy = 1'b1;
    for (int c = 0; c < 8; c++) all_rdy &= rdy0_tr[c];
    chk("wrap_ready0", all_rdy, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of write data.
REQ-002 Parameter ADDR_W, default 5, width of register index.
REQ-003 Parameter FIFO_DEPTH, default 2, entries per requester queue.
REQ-004 clock  input  1  single clock, all state on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 req0_valid  input  1  requester 0 offers a write.
REQ-007 req0_reg  input  ADDR_W  requester 0 destination register.
REQ-008 req0_data  input  DATA_W  requester 0 write data.
REQ-009 req0_ready  output  1  requester 0 queue can accept.
REQ-010 req1_valid, req1_reg, req1_data, req1_ready  same as REQ-006..009 for requester 1.
REQ-011 RegWrite  output  1  register-file write enable.
REQ-012 WriteReg  output  ADDR_W  register-file write index.
REQ-013 WriteData  output  DATA_W  register-file write data.
REQ-014 pending_mask  output  2**ADDR_W  bit r set while a write to register r is queued or on the output stage.

Function
REQ-015 Handshake: a request SHALL be accepted on a rising edge where valid and ready are both 1; data/reg SHALL be held stable by the requester while valid=1 and ready=0.
REQ-016 reqN_ready SHALL equal "queue N not full", with no combinational path from valid; full queue SHALL NOT accept, even if it issues on the same edge.
REQ-017 Accepted requests with reg index 0 SHALL be dropped: not queued, no pending bit, no register-file write.
REQ-018 Each queue SHALL be FIFO; order within a requester SHALL be preserved.
REQ-019 Each edge, if any queue is non-empty, exactly one head SHALL be granted and popped; if only one is non-empty it is granted.
REQ-020 If both are non-empty, the requester not granted last SHALL win (round-robin); pointer updates only on a grant.
REQ-021 Output stage SHALL be registered: grant at edge k drives RegWrite=1, WriteReg, WriteData during cycle k+1; RegWrite=0 in cycles following an edge with no grant.
REQ-022 Minimum latency: accepted at edge k, appears on outputs in cycle k+2 (register written at edge k+2).
REQ-023 Sustained throughput SHALL be one write per cycle with both requesters active, alternating 0,1,0,1.
REQ-024 pending_mask SHALL be the OR of decoded indices of all valid queue entries and of the output stage when RegWrite=1; combinational from state only.
REQ-025 Simultaneous push and pop on a non-full queue SHALL keep occupancy unchanged with correct ordering, including pointer wrap-around.

Reset
REQ-026 On reset_n=0, immediately and independent of clock: queues empty, RegWrite=0, WriteReg=0, WriteData=0, pending_mask=0, round-robin pointer favours requester 0 next.
REQ-027 Reset mid-operation SHALL discard all queued and in-flight writes; no RegWrite pulse SHALL occur in the cycle after reset deasserts.
REQ-028 reqN_ready SHALL read 1 during and after reset.

Structure
REQ-029 Package regfile_pkg SHALL hold DATA_W, ADDR_W, FIFO_DEPTH defaults and the wb_req_t record (reg index, data).
REQ-030 One sub-module wb_fifo (parameterised depth, push/pop/full/empty, entry-valid vector for pending decode) SHALL be instantiated twice.

Verification
REQ-031 Reset, then req0 writes r3=0x11 at edge 1 -> RegWrite=1, WriteReg=3, WriteData=0x11 in cycle 3 only; pending_mask bit 3 set cycles 2-3.
REQ-032 Both requesters stream 4 writes each (r1..r4 / r5..r8) from reset -> output order 0,1,0,1..., 8 consecutive RegWrite cycles, no loss.
REQ-033 req1 held valid, no issue possible until full -> req1_ready=0 after 2 accepts, recovers 1 one cycle after a pop; held data not duplicated.
REQ-034 req0 writes r0=0xFF -> no RegWrite, pending_mask stays 0, req0_ready stays 1.
REQ-035 reset_n pulsed low mid-edge with 3 entries queued -> outputs and pending_mask 0 immediately, no stale write after release.
REQ-036 Wrap-around: 6 back-to-back writes on req0 with continuous pop -> FIFO order preserved across pointer wrap.
